shaper_event_controller: RTL and testbench

- Sequences and supervises the trapezoidal shaping filter on one ADC channel.
- On enable it flushes the filter delay line by holding the filter in reset.
- It then watches the signed filter output for threshold crossings and measures the pulse amplitude over a fixed peak window.
- It flags pile-up inside a holdoff window and delivers one event per pulse (amplitude, timestamp, pile-up flag) on a valid/ready interface to the readout logic.

---
 rtl/shaper_event_controller.sv | 219 +++++++++++++++++++++
 tb/tb_shaper_event_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shaper_event_controller.sv
`default_nettype none
// ============================================================================
// Module      : shaper_event_controller
// Description : Sequences one trapezoidal shaping filter channel. Flushes the
//               filter on enable, triggers on rising threshold crossings,
//               searches for the peak, flags pile-up during holdoff and hands
//               one event per pulse to readout through a single-entry
//               valid/ready register.
// Revision    : 1.0 - initial release
// ============================================================================
module shaper_event_controller #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int PEAK_DELAY       = 6,
  parameter int HOLDOFF          = 20,
  parameter int FLUSH_CYCLES     = 16,
  parameter int TS_W             = 32,
  parameter int CNT_W            = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic signed [SIZE_FILTER_DATA+4:0] threshold,
  input  logic signed [SIZE_FILTER_DATA+4:0] filt_data,
  output logic                              filt_rst_n,
  output logic                              busy,
  output logic                              event_valid,
  input  logic                              event_ready,
  output logic signed [SIZE_FILTER_DATA+4:0] event_amp,
  output logic [TS_W-1:0]                   event_time,
  output logic                              event_pileup,
  output logic [CNT_W-1:0]                  drop_count
);

  localparam int C_DW = SIZE_FILTER_DATA + 5;

  // One shared sequencing counter covers flush, peak window and holdoff.
  localparam int C_SEQ_MAX = (FLUSH_CYCLES > HOLDOFF)
                           ? ((FLUSH_CYCLES > PEAK_DELAY) ? FLUSH_CYCLES : PEAK_DELAY)
                           : ((HOLDOFF > PEAK_DELAY) ? HOLDOFF : PEAK_DELAY);
  localparam int C_SEQ_W   = $clog2(C_SEQ_MAX + 1);

  localparam logic signed [C_DW-1:0] C_MAX_POS = {1'b0, {(C_DW-1){1'b1}}};

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_PEAK  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [C_SEQ_W-1:0]      seq_cnt_q, seq_cnt_d;
  logic [TS_W-1:0]         ts_q;
  logic signed [C_DW-1:0]  prev_q;

  // In-flight event being built by the FSM
  logic signed [C_DW-1:0]  amp_q, amp_d;
  logic [TS_W-1:0]         time_q, time_d;
  logic                    pileup_q, pileup_d;

  // Single-entry output event register
  logic                    evt_valid_q, evt_valid_d;
  logic signed [C_DW-1:0]  evt_amp_q, evt_amp_d;
  logic [TS_W-1:0]         evt_time_q, evt_time_d;
  logic                    evt_pileup_q, evt_pileup_d;
  logic [CNT_W-1:0]        drop_q, drop_d;

  logic                    crossing;
  logic                    commit;
  logic                    pop;

  assign crossing = (filt_data >= threshold) && (prev_q < threshold);
  assign pop      = evt_valid_q && event_ready;

  assign filt_rst_n   = (state_q == S_IDLE) || (state_q == S_PEAK) || (state_q == S_HOLD);
  assign busy         = (state_q == S_FLUSH) || (state_q == S_PEAK) || (state_q == S_HOLD);
  assign event_valid  = evt_valid_q;
  assign event_amp    = evt_amp_q;
  assign event_time   = evt_time_q;
  assign event_pileup = evt_pileup_q;
  assign drop_count   = drop_q;

  // Free-running timestamp and previous-sample register; during flush the
  // previous sample is pinned high so the first live sample cannot trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q   <= '0;
      prev_q <= '0;
    end else begin
      ts_q   <= ts_q + TS_W'(1);
      prev_q <= (state_q == S_FLUSH) ? C_MAX_POS : filt_data;
    end
  end

  // Sequencer next-state: flush, trigger, peak search, holdoff, abort on disable.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    amp_d     = amp_q;
    time_d    = time_q;
    pileup_d  = pileup_q;
    commit    = 1'b0;
    if ((state_q != S_OFF) && !enable) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          if (enable) begin
            state_d   = S_FLUSH;
            seq_cnt_d = '0;
          end
        end
        S_FLUSH: begin
          if (seq_cnt_q == C_SEQ_W'(FLUSH_CYCLES - 1)) begin
            state_d   = S_IDLE;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + C_SEQ_W'(1);
          end
        end
        S_IDLE: begin
          if (crossing) begin
            time_d    = ts_q;
            amp_d     = filt_data;
            pileup_d  = 1'b0;
            seq_cnt_d = '0;
            state_d   = S_PEAK;
          end
        end
        S_PEAK: begin
          if (filt_data > amp_q) begin
            amp_d = filt_data;
          end
          if (crossing) begin
            pileup_d = 1'b1;
          end
          if (seq_cnt_q == C_SEQ_W'(PEAK_DELAY - 1)) begin
            state_d   = S_HOLD;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + C_SEQ_W'(1);
          end
        end
        S_HOLD: begin
          if (crossing) begin
            pileup_d = 1'b1;
          end
          if (seq_cnt_q == C_SEQ_W'(HOLDOFF - 1)) begin
            commit    = 1'b1;
            state_d   = S_IDLE;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + C_SEQ_W'(1);
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end
  end

  // Sequencer state and in-flight event registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_OFF;
      seq_cnt_q <= '0;
      amp_q     <= '0;
      time_q    <= '0;
      pileup_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      amp_q     <= amp_d;
      time_q    <= time_d;
      pileup_q  <= pileup_d;
    end
  end

  // Event register next-state: load on commit if free or being popped, else
  // count a drop; a pop without commit empties it but keeps the data.
  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_amp_d    = evt_amp_q;
    evt_time_d   = evt_time_q;
    evt_pileup_d = evt_pileup_q;
    drop_d       = drop_q;
    if (commit && (!evt_valid_q || pop)) begin
      evt_valid_d  = 1'b1;
      evt_amp_d    = amp_q;
      evt_time_d   = time_q;
      evt_pileup_d = pileup_d;
    end else if (commit) begin
      if (drop_q != {CNT_W{1'b1}}) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end else if (pop) begin
      evt_valid_d = 1'b0;
    end
  end

  // Event register and drop counter storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid_q  <= 1'b0;
      evt_amp_q    <= '0;
      evt_time_q   <= '0;
      evt_pileup_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      evt_valid_q  <= evt_valid_d;
      evt_amp_q    <= evt_amp_d;
      evt_time_q   <= evt_time_d;
      evt_pileup_q <= evt_pileup_d;
      drop_q       <= drop_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shaper_event_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_shaper_event_controller
// Description : Directed self-checking bench for shaper_event_controller.
//               Cycle index cyc equals the DUT timestamp after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shaper_event_controller;

  localparam int DW = 21;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic signed [DW-1:0] threshold;
  logic signed [DW-1:0] filt_data;
  logic                 filt_rst_n;
  logic                 busy;
  logic                 event_valid;
  logic                 event_ready;
  logic [DW-1:0]        event_amp;
  logic [31:0]          event_time;
  logic                 event_pileup;
  logic [15:0]          drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  shaper_event_controller #(
    .SIZE_FILTER_DATA(16),
    .PEAK_DELAY(6),
    .HOLDOFF(20),
    .FLUSH_CYCLES(16),
    .TS_W(32),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .threshold(threshold),
    .filt_data(filt_data),
    .filt_rst_n(filt_rst_n),
    .busy(busy),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_amp(event_amp),
    .event_time(event_time),
    .event_pileup(event_pileup),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 'h%0h, expected 'h%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input int amp, input int t, input logic pile);
    logic [DW-1:0] ea;
    ea = DW'(amp);
    chk({tag, "_valid"},  64'(event_valid),  64'(1));
    chk({tag, "_amp"},    64'(event_amp),    64'(ea));
    chk({tag, "_time"},   64'(event_time),   64'(t));
    chk({tag, "_pileup"}, 64'(event_pileup), 64'(pile));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic play(input int v);
    filt_data = DW'(v);
    step();
  endtask

  task automatic idle_to(input int c, input int v);
    while (cyc < c) play(v);
  endtask

  int p_single[9] = '{0, 50, 120, 300, 410, 420, 415, 380, 200};
  int p_pile[11]  = '{200, 250, 300, 280, 200, 150, 100, 90, 90, 90, 150};

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    event_ready = 1'b1;
    threshold   = DW'(100);
    filt_data   = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_filt_rst_n", 64'(filt_rst_n),   64'(0));
    chk("rst_busy",       64'(busy),         64'(0));
    chk("rst_valid",      64'(event_valid),  64'(0));
    chk("rst_amp",        64'(event_amp),    64'(0));
    chk("rst_time",       64'(event_time),   64'(0));
    chk("rst_pileup",     64'(event_pileup), 64'(0));
    chk("rst_drop",       64'(drop_count),   64'(0));

    // Flush: enable at cycle 0, filter held in reset through cycle 16
    reset     = 1'b0;
    enable    = 1'b1;
    filt_data = DW'(500);
    cyc       = 0;
    chk("off_filt_rst_n", 64'(filt_rst_n), 64'(0));
    chk("off_busy",       64'(busy),       64'(0));
    while (cyc < 16) begin
      play(500);
      chk("flush_filt_rst_n", 64'(filt_rst_n), 64'(0));
      chk("flush_busy",       64'(busy),       64'(1));
    end
    play(500);
    chk("idle_filt_rst_n", 64'(filt_rst_n), 64'(1));
    chk("idle_busy",       64'(busy),       64'(0));
    play(500);
    chk("no_trig_500_a", 64'(busy), 64'(0));
    idle_to(21, 500);
    chk("no_trig_500_b", 64'(busy), 64'(0));
    idle_to(45, 0);
    chk("no_event_after_flush", 64'(event_valid), 64'(0));

    // Single pulse, trigger sample 120 at ts=1000
    idle_to(998, 0);
    foreach (p_single[i]) play(p_single[i]);
    idle_to(1026, 0);
    chk("single_pre_valid", 64'(event_valid), 64'(0));
    chk("single_pre_busy",  64'(busy),        64'(1));
    play(0);
    chk_evt("single", 420, 1000, 1'b0);
    chk("single_busy_done", 64'(busy), 64'(0));
    play(0);
    chk("single_popped",   64'(event_valid), 64'(0));
    chk("single_amp_hold", 64'(event_amp),   64'(420));

    // Pile-up: second crossing (90 -> 150) at trigger+10
    idle_to(1100, 0);
    foreach (p_pile[i]) play(p_pile[i]);
    idle_to(1127, 0);
    chk_evt("pile", 300, 1100, 1'b1);
    idle_to(1137, 0);
    chk("pile_no_second_valid", 64'(event_valid), 64'(0));
    chk("pile_no_second_busy",  64'(busy),        64'(0));

    // Back-pressure: three isolated pulses with event_ready low
    event_ready = 1'b0;
    idle_to(1200, 0);
    play(201);
    idle_to(1227, 0);
    chk_evt("bp1", 201, 1200, 1'b0);
    chk("bp1_drop", 64'(drop_count), 64'(0));
    idle_to(1300, 0);
    play(202);
    idle_to(1327, 0);
    chk_evt("bp2_held", 201, 1200, 1'b0);
    chk("bp2_drop", 64'(drop_count), 64'(1));
    idle_to(1400, 0);
    play(203);
    idle_to(1427, 0);
    chk_evt("bp3_held", 201, 1200, 1'b0);
    chk("bp3_drop", 64'(drop_count), 64'(2));
    idle_to(1450, 0);
    event_ready = 1'b1;
    play(0);
    event_ready = 1'b0;
    chk("bp_pop_valid",    64'(event_valid), 64'(0));
    chk("bp_pop_amp_hold", 64'(event_amp),   64'(201));
    chk("bp_pop_drop",     64'(drop_count),  64'(2));

    // Simultaneous commit and pop
    idle_to(1500, 0);
    play(204);
    idle_to(1527, 0);
    chk_evt("sim_first", 204, 1500, 1'b0);
    idle_to(1540, 0);
    play(205);
    idle_to(1566, 0);
    chk_evt("sim_before", 204, 1500, 1'b0);
    event_ready = 1'b1;
    play(0);
    chk_evt("sim_after", 205, 1540, 1'b0);
    chk("sim_drop", 64'(drop_count), 64'(2));
    play(0);
    chk("sim_popped", 64'(event_valid), 64'(0));

    // Abort during PEAK, then re-enable and re-flush
    idle_to(1600, 0);
    play(200);
    chk("abort_in_peak", 64'(busy), 64'(1));
    idle_to(1603, 0);
    enable = 1'b0;
    play(0);
    chk("abort_busy",       64'(busy),       64'(0));
    chk("abort_filt_rst_n", 64'(filt_rst_n), 64'(0));
    idle_to(1640, 0);
    chk("abort_no_event", 64'(event_valid), 64'(0));
    idle_to(1650, 0);
    enable = 1'b1;
    play(0);
    chk("reflush_busy",       64'(busy),       64'(1));
    chk("reflush_filt_rst_n", 64'(filt_rst_n), 64'(0));
    idle_to(1666, 0);
    chk("reflush_last_filt_rst_n", 64'(filt_rst_n), 64'(0));
    play(0);
    chk("reflush_done_filt_rst_n", 64'(filt_rst_n), 64'(1));
    chk("reflush_done_busy",       64'(busy),       64'(0));

    // Negative threshold: -60 then -50 triggers on the -50 sample
    idle_to(1670, 0);
    threshold = DW'(-50);
    idle_to(1680, 0);
    play(-60);
    chk("neg_no_trig_m60", 64'(busy), 64'(0));
    play(-50);
    chk("neg_trig", 64'(busy), 64'(1));
    idle_to(1707, -100);
    chk("neg_pre_valid", 64'(event_valid), 64'(0));
    play(-100);
    chk_evt("neg", -50, 1681, 1'b0);

    // Samples sitting exactly at threshold from IDLE entry never trigger
    idle_to(1710, -100);
    enable = 1'b0;
    idle_to(1720, -50);
    enable = 1'b1;
    idle_to(1737, -50);
    chk("eq_idle_filt_rst_n", 64'(filt_rst_n), 64'(1));
    chk("eq_idle_busy",       64'(busy),       64'(0));
    play(-50);
    chk("eq_no_trig_a", 64'(busy), 64'(0));
    idle_to(1770, -50);
    chk("eq_no_trig_b",   64'(busy),        64'(0));
    chk("eq_no_event",    64'(event_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
